disp_scan_ctrl: RTL and testbench
=================================

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 SHALL provide parameter SLOT_CYCLES, default 50000: clock cycles per digit slot, including the gap; legal range >= 2.
REQ-002 SHALL provide parameter GAP_CYCLES, default 500: all-anodes-off cycles at the start of each slot; legal range 0 <= GAP_CYCLES < SLOT_CYCLES.
REQ-003 iClk  in  1  sole clock; all state updates on rising edge.
REQ-004 iReset  in  1  synchronous, active-high reset.
REQ-005 iWrEn  in  1  one-cycle write strobe for iData/iDp.
REQ-006 iData  in  16  four hex nibbles; [3:0] = digit 0 (least significant), [15:12] = digit 3.
REQ-007 iDp  in  4  decimal-point request per digit, active high; bit k = digit k.
REQ-008 iBlankLz  in  1  leading-zero blanking enable, sampled live (not buffered).
REQ-009 oHex  out  4  nibble of the current digit, feeding the downstream hex-to-segment decoder.
REQ-010 oAn  out  4  digit anode enables, active low; bit k = digit k.
REQ-011 oDp  out  1  decimal-point segment, active low.
REQ-012 oPending  out  1  shadow holds data not yet shown.
REQ-013 oFrame  out  1  one-cycle frame-boundary strobe.

Function
REQ-014 SHALL keep a slot counter cnt (0..SLOT_CYCLES-1) and a digit index idx (0..3); cnt increments every cycle.
- At cnt == SLOT_CYCLES-1: cnt -> 0 and idx -> idx+1, wrapping 3 -> 0.
REQ-015 SHALL have phase GAP while cnt < GAP_CYCLES and phase SHOW otherwise.
- When GAP_CYCLES = 0, there is no GAP phase.
REQ-016 SHALL hold two register sets:
- Shadow (data16, dp4, pending bit).
- Active (data16, dp4), which alone drives the outputs.
REQ-017 iWrEn = 1 SHALL load iData/iDp into the shadow and set oPending = 1 on the next edge; back-to-back writes SHALL overwrite, and the last one wins.
REQ-018 The frame boundary is the cycle with idx == 3 and cnt == SLOT_CYCLES-1; oFrame SHALL be 1 in exactly that cycle (combinational decode of state).
REQ-019 At the frame boundary with oPending = 1, the active set SHALL load the shadow and oPending SHALL clear; active data never changes at any other time, so there is no tearing.
REQ-020 iWrEn in the frame-boundary cycle:
- The active set SHALL load the old shadow contents.
- The shadow SHALL load the new data.
- oPending SHALL remain 1, so the new data is shown from the following frame.
REQ-021 oHex SHALL equal active nibble[idx] in every cycle, including GAP.
REQ-022 Digit k is blanked when all of the following hold:
- iBlankLz = 1 and k != 0;
- active nibbles k..3 are all zero;
- active dp[k] = 0.
- Digit 0 is never blanked.
REQ-023 oAn SHALL be 4'b1111 in GAP or when digit idx is blanked; otherwise oAn = ~(1 << idx).
REQ-024 oDp SHALL be ~active dp[idx] when oAn != 4'b1111, and 1 otherwise.
REQ-025 oAn, oDp, oHex and oFrame SHALL be combinational decodes of registered state only: no iData, iDp or iWrEn paths to outputs; iBlankLz is the only direct input (to oAn and oDp).
REQ-026 Write-to-display latency SHALL be: the write edge, then the next frame boundary, then the first SHOW cycle of digit 0 (GAP_CYCLES cycles after the boundary).

Reset
REQ-027 iReset = 1 at an edge SHALL clear cnt, idx, active data/dp, shadow data/dp and pending, overriding any simultaneous iWrEn or boundary transfer.
REQ-028 Output values in the cycle after reset:
- GAP_CYCLES > 0: oAn = 4'b1111, oDp = 1, oHex = 4'h0, oPending = 0, oFrame = 0.
- GAP_CYCLES = 0: oAn = 4'b1110 instead; the other values are unchanged.
REQ-029 Reset mid-operation SHALL discard any pending shadow data; no partial frame continues.

Verification (SLOT_CYCLES = 8, GAP_CYCLES = 2, cycle 0 = first cycle after reset release)
REQ-030 Idle after reset, iBlankLz = 0 -> expected response:
- cycles 0-1: oAn = 1111;
- cycles 2-7: oAn = 1110, oHex = 0, oDp = 1;
- cycle 31: oFrame = 1 (the only oFrame pulse in cycles 0-31).
REQ-031 iWrEn with 16'h1234 at cycle 5 -> expected response:
- oPending = 1 from cycle 6;
- digits show 0 until cycle 31;
- oPending = 0 from cycle 32;
- cycles 34-39: oAn = 1110, oHex = 4;
- cycles 42-47: oAn = 1101, oHex = 3.
REQ-032 Data 16'h0050, iBlankLz = 1 -> expected response:
- digits 3 and 2: oAn = 1111 throughout their slots;
- digit 1: oHex = 5;
- digit 0: oHex = 0, lit;
- data 16'h0000 lights only digit 0.
REQ-033 Write 16'hAAAA at cycle 10, then 16'hBBBB at cycle 31 -> expected response:
- frame 2 (cycles 32-63) shows A;
- oPending stays 1 through cycle 63;
- frame 3 shows B and oPending clears at cycle 64.
REQ-034 Data 16'h0000, iDp = 4'b0100, iBlankLz = 1 -> expected response:
- digit 2 lit with oHex = 0 and oDp = 0 during its SHOW;
- digit 3 blanked;
- oDp = 1 in all other cycles.
REQ-035 Write pending, iReset pulsed at idx = 2, cnt = 5 -> expected response:
- next cycle: all REQ-028 reset values, oPending = 0;
- the next frame shows 0000.

Source files
------------

// File: rtl/disp_scan_ctrl_if.sv
// Bus bundle for the multiplexed 4-digit display scanner: the write port,
// the blanking control and the scan outputs.
interface disp_scan_ctrl_if;
    logic        iWrEn;
    logic [15:0] iData;
    logic [3:0]  iDp;
    logic        iBlankLz;
    logic [3:0]  oHex;
    logic [3:0]  oAn;
    logic        oDp;
    logic        oPending;
    logic        oFrame;

    modport master (
        output iWrEn, iData, iDp, iBlankLz,
        input  oHex, oAn, oDp, oPending, oFrame
    );

    modport slave (
        input  iWrEn, iData, iDp, iBlankLz,
        output oHex, oAn, oDp, oPending, oFrame
    );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed display scanner. Each digit owns a slot of
// SLOT_CYCLES clocks, the first GAP_CYCLES of which keep all anodes off to
// avoid ghosting. New data lands in a shadow set and is copied to the
// active set only at the frame boundary, so a frame is never torn.
module disp_scan_ctrl #(
    parameter int SLOT_CYCLES = 50000,
    parameter int GAP_CYCLES  = 500
) (
    input  logic      iClk,
    input  logic      iReset,
    disp_scan_ctrl_if.slave bus
);
    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   sh_data;
    logic [3:0]    sh_dp;
    logic          pending;
    logic [15:0]   act_data;
    logic [3:0]    act_dp;

    logic          slot_end;
    logic          frame_end;
    logic          in_gap;
    logic [3:0]    zero_from;
    logic [3:0]    blank;
    logic [3:0]    an;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == 2'd3);

    // With no gap configured the digit is lit for the whole slot.
    generate
        if (GAP_CYCLES == 0) begin : g_no_gap
            assign in_gap = 1'b0;
        end else begin : g_gap
            assign in_gap = (cnt < CW'(GAP_CYCLES));
        end
    endgenerate

    // Slot timer, digit index, shadow/active register sets.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            cnt      <= '0;
            idx      <= '0;
            sh_data  <= '0;
            sh_dp    <= '0;
            pending  <= 1'b0;
            act_data <= '0;
            act_dp   <= '0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (frame_end && pending) begin
                act_data <= sh_data;
                act_dp   <= sh_dp;
                pending  <= 1'b0;
            end

            // A write in the boundary cycle re-arms pending after the copy.
            if (bus.iWrEn) begin
                sh_data <= bus.iData;
                sh_dp   <= bus.iDp;
                pending <= 1'b1;
            end
        end
    end

    // Leading-zero blanking: digit k goes dark when it and every digit above
    // it are zero and it carries no decimal point. Digit 0 always shows.
    always_comb begin
        zero_from    = '0;
        blank        = '0;
        zero_from[3] = (act_data[15:12] == 4'h0);
        zero_from[2] = zero_from[3] && (act_data[11:8] == 4'h0);
        zero_from[1] = zero_from[2] && (act_data[7:4] == 4'h0);
        zero_from[0] = zero_from[1] && (act_data[3:0] == 4'h0);
        for (int k = 1; k < 4; k++) begin
            blank[k] = bus.iBlankLz && zero_from[k] && !act_dp[k];
        end
    end

    // Anode select for the current digit, dark in the gap or when blanked.
    always_comb begin
        an = 4'b1111;
        if (!in_gap && !blank[idx]) begin
            an = ~(4'b0001 << idx);
        end
    end

    assign bus.oAn      = an;
    assign bus.oHex     = act_data[{idx, 2'b00} +: 4];
    assign bus.oDp      = (an != 4'b1111) ? ~act_dp[idx] : 1'b1;
    assign bus.oPending = pending;
    assign bus.oFrame   = frame_end;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl with a frame-level reference model.
module tb_disp_scan_ctrl;
    localparam int SLOT = 8;
    localparam int GAP  = 2;

    logic clk;
    logic rst;

    disp_scan_ctrl_if bus ();

    disp_scan_ctrl #(.SLOT_CYCLES(SLOT), .GAP_CYCLES(GAP)) dut (
        .iClk   (clk),
        .iReset (rst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [3:0] hex;
        logic       dp;
        logic       pend;
        logic       frame;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: cycle number since reset plus the two register sets.
    int          m_t;
    logic [15:0] m_sh, m_act;
    logic [3:0]  m_shdp, m_actdp;
    bit          m_pend;

    task automatic model_reset();
        m_t = 0; m_sh = '0; m_act = '0; m_shdp = '0; m_actdp = '0; m_pend = 0;
    endtask

    // One cycle: drive inputs, predict this cycle's outputs, advance the model.
    task automatic step(input bit r, input bit wr, input logic [15:0] d,
                        input logic [3:0] p, input bit blz);
        exp_t e;
        int   slot_pos, digit;
        bit   gap, blk;
        rst          = r;
        bus.iWrEn    = wr;
        bus.iData    = d;
        bus.iDp      = p;
        bus.iBlankLz = blz;

        slot_pos = m_t % SLOT;
        digit    = (m_t / SLOT) % 4;
        gap      = slot_pos < GAP;
        blk      = blz && digit != 0 && ((m_act >> (4 * digit)) == 16'h0)
                   && !m_actdp[digit];
        e.an    = (gap || blk) ? 4'b1111 : 4'(~(1 << digit));
        e.hex   = 4'((m_act >> (4 * digit)) & 16'hF);
        e.dp    = (e.an == 4'b1111) ? 1'b1 : ~m_actdp[digit];
        e.pend  = m_pend;
        e.frame = (digit == 3) && (slot_pos == SLOT - 1);
        e.cyc   = m_t;
        exp_q.push_back(e);

        if (r) begin
            model_reset();
        end else begin
            if (e.frame && m_pend) begin
                m_act = m_sh; m_actdp = m_shdp; m_pend = 0;
            end
            if (wr) begin
                m_sh = d; m_shdp = p; m_pend = 1;
            end
            m_t = (m_t + 1) % (4 * SLOT);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit blz);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, 4'h0, blz);
    endtask

    task automatic chk(input string nm, input int cyc, input logic [3:0] act,
                       input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s cycle=%0d actual=%b required=%b", nm, cyc, act, req);
        end
    endtask

    // Monitor: outputs are valid every cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("oAn",      e.cyc, bus.oAn,               e.an);
                chk("oHex",     e.cyc, bus.oHex,              e.hex);
                chk("oDp",      e.cyc, {3'b000, bus.oDp},      {3'b000, e.dp});
                chk("oPending", e.cyc, {3'b000, bus.oPending}, {3'b000, e.pend});
                chk("oFrame",   e.cyc, {3'b000, bus.oFrame},   {3'b000, e.frame});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] rnd_data();
        logic [15:0] v;
        for (int k = 0; k < 4; k++)
            v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        return v;
    endfunction

    initial begin
        rst = 1'b1; bus.iWrEn = 1'b0; bus.iData = '0; bus.iDp = '0; bus.iBlankLz = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Idle after reset
        idle(40, 0);

        // Single write at cycle 5
        step(1, 0, 16'h0, 4'h0, 0);
        idle(5, 0);
        step(0, 1, 16'h1234, 4'h0, 0);
        idle(60, 0);

        // Leading-zero blanking, then all-zero data
        step(1, 0, 16'h0, 4'h0, 1);
        step(0, 1, 16'h0050, 4'h0, 1);
        idle(90, 1);
        step(0, 1, 16'h0000, 4'h0, 1);
        idle(70, 1);

        // Writes at cycle 10 and in the frame-boundary cycle 31
        step(1, 0, 16'h0, 4'h0, 0);
        idle(10, 0);
        step(0, 1, 16'hAAAA, 4'h0, 0);
        idle(20, 0);
        step(0, 1, 16'hBBBB, 4'h0, 0);
        idle(70, 0);

        // Decimal point keeps an otherwise blank digit lit
        step(1, 0, 16'h0, 4'h0, 1);
        step(0, 1, 16'h0000, 4'b0100, 1);
        idle(100, 1);

        // Reset with a write pending at idx 2, cnt 5
        step(1, 0, 16'h0, 4'h0, 0);
        idle(3, 0);
        step(0, 1, 16'h9876, 4'hF, 0);
        idle(17, 0);
        step(1, 1, 16'h5555, 4'hF, 0);
        idle(70, 0);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            bit r, w, b;
            r = ($urandom_range(0, 299) == 0);
            w = ($urandom_range(0, 7) == 0);
            b = ($urandom_range(0, 3) != 0);
            step(r, w, rnd_data(), 4'($urandom), b);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
